dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory-side responder for the 5-stage pipelined processor. It services the processor's dmem port (address_dmem/data/wren in, q_dmem out).
- Backs a word-addressed RAM plus a small MMIO window: a cycle counter, an LED register and a byte TX FIFO.
- The FIFO drains to an external consumer over a ready/valid port.
- Sits in Wrapper beside imem/regfile and replaces the plain dmem instance.

Parameters:
- ADDR_WIDTH, 12, log2 of RAM depth in 32-bit words; RAM index = address_dmem[ADDR_WIDTH-1:0].
- LED_WIDTH, 8, width of LED output register.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address_dmem  in  32  word address from the processor memory stage.
- data  in  32  store data.
- wren  in  1  store enable.
- q_dmem  out  32  load data, registered.
- leds  out  LED_WIDTH  LED register contents.
- tx_valid  out  1  FIFO head valid (FIFO not empty).
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts the head byte when tx_valid & tx_ready.

Behaviour:
- Decode:
  - MMIO when address_dmem[31:4] == 28'hFFFFF00.
  - RAM otherwise, using the low ADDR_WIDTH bits; upper bits are ignored (aliasing allowed).
- MMIO map (word addresses):
  - 0xFFFFF000 CYCLE: RO, free-running 32-bit counter, +1 every clock, wraps 0xFFFFFFFF -> 0.
  - 0xFFFFF001 LED: RW. Write takes data[LED_WIDTH-1:0]; read zero-extends.
  - 0xFFFFF002 TX: write pushes data[7:0]. Read returns {26'b0, count[3:0], full, empty}, with count zero-extended to 4 bits.
  - 0xFFFFF003 DROP: RO 16-bit dropped-push counter, zero-extended, saturates at 0xFFFF. A write of any value clears it.
  - 0xFFFFF004-00F: reads return 0; writes are ignored.
- Load timing:
  - q_dmem is registered: it reflects the address sampled at rising edge N, valid after edge N.
  - The processor's falling-edge W latch captures it within the same cycle, so the effective latency is one rising edge.
- RAM store: on a rising edge with wren=1 and a RAM-decoded address.
- Same-address read and write on one edge: read-first, so q_dmem returns the old word.
- MMIO reads sample the value before that edge's update:
  - CYCLE returns the pre-increment value.
  - TX status returns pre-push/pop state.
- TX FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH; empty = (count==0); full = (count==FIFO_DEPTH).
  - tx_valid = ~empty; tx_data = entry at the read pointer (combinational from storage).
  - Pop = tx_valid & tx_ready. Push = wren to TX address.
  - Push while full with a simultaneous pop: accepted, count unchanged.
  - Push while full with no pop: dropped, DROP increments (saturating).
  - Pop while empty: cannot occur (tx_valid=0); no state change.
  - Push and pop together when not full and not empty: count unchanged.
- Reset (asynchronous):
  - Cleared to 0: q_dmem, leds, CYCLE, DROP, FIFO pointers and count; tx_valid=0.
  - RAM contents and FIFO storage are not reset.
  - Reset mid-transaction discards the pending store and any FIFO contents.
- wren is only honoured on the rising edge; there is no multi-cycle handshake toward the processor, which never stalls on dmem.

Decomposition:
- Shared package dmem_pkg:
  - MMIO base and offsets (CYCLE/LED/TX/DROP).
  - MMIO decode mask.
  - TX status bit positions.
  - DROP counter width (16).
- Sub-module tx_fifo, parameterised by DEPTH and WIDTH:
  - Inputs: push, push_data, pop.
  - Outputs: head, count, full, empty.
- Top level holds RAM, decode, read mux, CYCLE/LED/DROP registers.

Test Plan:
- RAM store then load: store 0xDEADBEEF to word 5, then load word 5 -> q_dmem=0xDEADBEEF one edge later. Load word 5+2^ADDR_WIDTH -> same value (aliasing).
- Read-first collision: word 7 holds 0x1, same edge loads word 7 and stores 0x2 -> q_dmem=0x1; next load -> 0x2.
- CYCLE: release reset, read 0xFFFFF000 at edge 10 -> 9 (pre-increment). Force counter to 0xFFFFFFFF -> next read wraps to 0.
- LED: write 0x1A5 to 0xFFFFF001 -> leds=0xA5 (LED_WIDTH=8); read returns 0x000000A5. Assert reset -> leds=0 immediately, without waiting for a clock edge.
- FIFO overflow: tx_ready=0, push 0x41..0x45 -> status shows count=4 and full=1, DROP=1. Raise tx_ready -> tx_data drains 0x41,0x42,0x43,0x44 on consecutive edges, then tx_valid=0.
- Full push with pop: FIFO full, push 0x55 while tx_ready=1 -> push accepted, count stays 4, DROP unchanged, 0x55 appears as the last drained byte.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder: MMIO window location,
// register offsets inside the window, TX status bit layout and the width of
// the dropped-push counter.
// No ports (package).

package dmem_pkg;

  // MMIO window: sixteen word addresses starting at 0xFFFFF000
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_F000;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_FFF0;

  // Word offsets of the MMIO registers inside the window
  typedef enum logic [3:0] {
    REG_CYCLE = 4'h0,
    REG_LED   = 4'h1,
    REG_TX    = 4'h2,
    REG_DROP  = 4'h3
  } mmio_reg_e;

  // TX status word layout: {count, full, empty} in the low bits
  localparam int TX_STAT_EMPTY     = 0;
  localparam int TX_STAT_FULL      = 1;
  localparam int TX_STAT_COUNT_LSB = 2;
  localparam int TX_STAT_COUNT_W   = 4;

  // Dropped-push counter width
  localparam int DROP_WIDTH = 16;

  // True when a word address falls inside the MMIO window
  function automatic logic isMmioAddr(input logic [31:0] addr);
    return (addr & MMIO_MASK) == MMIO_BASE;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Bundles the processor dmem port and the TX drain port.
//   address_dmem, data, wren : processor word address, store data, store enable
//   q_dmem                   : registered load data back to the processor
//   tx_valid, tx_data        : TX FIFO head presented to the consumer
//   tx_ready                 : consumer accepts the head byte
// Modports: master = processor/consumer side, slave = responder side.

interface dmem_responder_if;

  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_valid, tx_data
  );

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_valid, tx_data
  );

endinterface

// File: rtl/tx_fifo.sv
// tx_fifo
// Circular-buffer FIFO. A push while full is only accepted when a pop happens
// on the same edge, so the caller can treat full & push & ~pop as a drop.
//   clk_i, rst_i   : clock, asynchronous active-high reset (pointers/count only)
//   push_i         : write push_data_i at the tail
//   push_data_i    : data to store
//   pop_i          : remove the head entry (ignored while empty)
//   head_o         : entry at the read pointer, combinational from storage
//   count_o        : number of stored entries, 0..DEPTH
//   full_o/empty_o : count_o == DEPTH / count_o == 0

module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             popOk, pushOk;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem[rd_q];

  // A pop frees a slot on the same edge, letting a push into a full FIFO land
  assign popOk  = pop_i & ~empty_o;
  assign pushOk = push_i & (~full_o | popOk) & ~rst_i;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (pushOk) wr_d = wr_q + PW'(1);
    if (popOk)  rd_d = rd_q + PW'(1);
    if (pushOk && !popOk)      count_d = count_q + CW'(1);
    else if (popOk && !pushOk) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (pushOk) mem[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Services the processor dmem port: a word-addressed RAM plus an MMIO window
// holding a free-running cycle counter, an LED register, a byte TX FIFO and a
// saturating dropped-push counter. Loads are registered and read-first.
//   clk_i    : clock, all state changes on the rising edge
//   rst_i    : asynchronous active-high reset
//   dmem_io  : processor dmem port and TX drain port (slave modport)
//   leds_o   : LED register contents

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LED_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dmem_responder_if.slave      dmem_io,
  output logic [LED_WIDTH-1:0] leds_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ramIdx;
  logic [3:0]            mmioOff;
  logic                  isMmio;

  logic [31:0]           cycle_q;
  logic [LED_WIDTH-1:0]  led_q;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mmioRdata, txStatus;

  logic                  txPush, txPop, fifoFull, fifoEmpty;
  logic [CW-1:0]         fifoCount;
  logic [7:0]            fifoHead;

  // Upper address bits above the RAM index are ignored, so RAM aliases
  assign isMmio  = isMmioAddr(dmem_io.address_dmem);
  assign mmioOff = dmem_io.address_dmem[3:0];
  assign ramIdx  = dmem_io.address_dmem[ADDR_WIDTH-1:0];

  assign txPush = dmem_io.wren & isMmio & (mmioOff == REG_TX);
  assign txPop  = ~fifoEmpty & dmem_io.tx_ready;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (txPush),
    .push_data_i (dmem_io.data[7:0]),
    .pop_i       (txPop),
    .head_o      (fifoHead),
    .count_o     (fifoCount),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  assign dmem_io.tx_valid = ~fifoEmpty;
  assign dmem_io.tx_data  = fifoHead;
  assign dmem_io.q_dmem   = rdata_q;
  assign leds_o           = led_q;

  // Status is built from the pre-edge FIFO state so reads see pre-push/pop
  always_comb begin
    txStatus = '0;
    txStatus[TX_STAT_EMPTY] = fifoEmpty;
    txStatus[TX_STAT_FULL]  = fifoFull;
    txStatus[TX_STAT_COUNT_LSB +: TX_STAT_COUNT_W] = TX_STAT_COUNT_W'(fifoCount);
  end

  // Read mux; all sources are pre-edge values, giving read-first behaviour
  always_comb begin
    mmioRdata = '0;
    case (mmioOff)
      REG_CYCLE: mmioRdata = cycle_q;
      REG_LED:   mmioRdata = 32'(led_q);
      REG_TX:    mmioRdata = txStatus;
      REG_DROP:  mmioRdata = 32'(drop_q);
      default:   mmioRdata = '0;
    endcase
    rdata_d = isMmio ? mmioRdata : ram[ramIdx];
  end

  // A full FIFO without a simultaneous pop loses the byte; count it, saturating
  always_comb begin
    drop_d = drop_q;
    if (dmem_io.wren && isMmio && (mmioOff == REG_DROP)) begin
      drop_d = '0;
    end else if (txPush && fifoFull && !txPop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      cycle_q <= '0;
      led_q   <= '0;
      drop_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      cycle_q <= cycle_q + 32'd1;
      drop_q  <= drop_d;
      if (dmem_io.wren && isMmio && (mmioOff == REG_LED)) begin
        led_q <= dmem_io.data[LED_WIDTH-1:0];
      end
    end
  end

  // RAM contents survive reset, but a store is suppressed while reset is held
  always_ff @(posedge clk_i) begin
    if (dmem_io.wren && !isMmio && !rst_i) ram[ramIdx] <= dmem_io.data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed and randomized checks of dmem_responder against a queue/array
// reference model of the memory map.

module tb_dmem_responder;

   localparam logic [31:0] CYCLE_A = 32'hFFFF_F000;
   localparam logic [31:0] LED_A   = 32'hFFFF_F001;
   localparam logic [31:0] TX_A    = 32'hFFFF_F002;
   localparam logic [31:0] DROP_A  = 32'hFFFF_F003;
   localparam logic [31:0] IDLE_A  = 32'h0000_0100;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] leds;

   int checks = 0;
   int errors = 0;

   logic [31:0] mRam [int];
   logic [7:0]  mFifo [$];
   logic [31:0] mCycle;
   logic [7:0]  mLed;
   logic [15:0] mDrop;
   logic [31:0] expQ;
   bit          qKnown;

   dmem_responder_if dmem();

   dmem_responder #(
      .ADDR_WIDTH (12),
      .LED_WIDTH  (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i   (clock),
      .rst_i   (reset),
      .dmem_io (dmem.slave),
      .leds_o  (leds)
   );

   // Free-running 10-unit clock
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any failure
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model goes back to its post-reset state; RAM contents survive
   task automatic resetModel();
      mFifo.delete();
      mCycle = '0;
      mLed   = '0;
      mDrop  = '0;
   endtask

   // Compare every visible output against the model after an edge
   task automatic checkOutput();
      if (qKnown) check("q_dmem", dmem.q_dmem, expQ);
      check("leds", 32'(leds), 32'(mLed));
      check("tx_valid", 32'(dmem.tx_valid), 32'(mFifo.size() > 0));
      if (mFifo.size() > 0) check("tx_data", 32'(dmem.tx_data), 32'(mFifo[0]));
   endtask

   // Drive one bus cycle starting at a falling edge, advance the model over
   // the next rising edge, check shortly after it, and return at the next
   // falling edge
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic r);
      logic       mmio;
      logic [3:0] off;
      int         idx;
      dmem.address_dmem = a;
      dmem.data         = d;
      dmem.wren         = w;
      dmem.tx_ready     = r;
      mmio = (a[31:4] == 28'hFFFFF00);
      off  = a[3:0];
      idx  = int'(a[11:0]);
      qKnown = 1'b1;
      expQ   = '0;
      if (mmio) begin
         case (off)
            4'h0:    expQ = mCycle;
            4'h1:    expQ = 32'(mLed);
            4'h2:    expQ = {26'b0, 4'(mFifo.size()), (mFifo.size() == 4), (mFifo.size() == 0)};
            4'h3:    expQ = 32'(mDrop);
            default: expQ = '0;
         endcase
      end else if (mRam.exists(idx)) begin
         expQ = mRam[idx];
      end else begin
         qKnown = 1'b0;
      end
      if (r && mFifo.size() > 0) void'(mFifo.pop_front());
      if (w && mmio && off == 4'h2) begin
         if (mFifo.size() < 4) mFifo.push_back(d[7:0]);
         else if (mDrop != 16'hFFFF) mDrop++;
      end
      if (w && mmio && off == 4'h1) mLed = d[7:0];
      if (w && mmio && off == 4'h3) mDrop = '0;
      if (w && !mmio) mRam[idx] = d;
      mCycle++;
      @(posedge clock);
      #1;
      checkOutput();
      @(negedge clock);
   endtask

   initial begin
      logic [7:0]  heads [4];
      logic [31:0] a;

      // Reset state
      reset = 1'b1;
      dmem.address_dmem = '0;
      dmem.data         = '0;
      dmem.wren         = 1'b0;
      dmem.tx_ready     = 1'b0;
      resetModel();
      qKnown = 1'b0;
      #12;
      check("reset_q", dmem.q_dmem, 32'h0);
      check("reset_leds", 32'(leds), 32'h0);
      check("reset_tx_valid", 32'(dmem.tx_valid), 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // CYCLE: nine idle edges, then the tenth edge samples the value 9
      for (int i = 0; i < 9; i++) applyStimulus(IDLE_A, 32'h0, 1'b0, 1'b0);
      applyStimulus(CYCLE_A, 32'h0, 1'b0, 1'b0);
      check("cycle_edge10", dmem.q_dmem, 32'd9);

      // RAM store/load and aliasing
      applyStimulus(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
      applyStimulus(32'd5, 32'h0, 1'b0, 1'b0);
      check("ram_load5", dmem.q_dmem, 32'hDEAD_BEEF);
      applyStimulus(32'd5 + 32'd4096, 32'h0, 1'b0, 1'b0);
      check("ram_alias5", dmem.q_dmem, 32'hDEAD_BEEF);

      // Read-first collision
      applyStimulus(32'd7, 32'h1, 1'b1, 1'b0);
      applyStimulus(32'd7, 32'h2, 1'b1, 1'b0);
      check("collision_old", dmem.q_dmem, 32'h1);
      applyStimulus(32'd7, 32'h0, 1'b0, 1'b0);
      check("collision_new", dmem.q_dmem, 32'h2);

      // LED write truncates, read zero-extends
      applyStimulus(LED_A, 32'h1A5, 1'b1, 1'b0);
      check("led_out", 32'(leds), 32'hA5);
      applyStimulus(LED_A, 32'h0, 1'b0, 1'b0);
      check("led_read", dmem.q_dmem, 32'h0000_00A5);

      // FIFO overflow with the consumer stalled
      for (int i = 0; i < 5; i++) applyStimulus(TX_A, 32'h41 + 32'(i), 1'b1, 1'b0);
      applyStimulus(TX_A, 32'h0, 1'b0, 1'b0);
      check("ovf_status", dmem.q_dmem, 32'h12);
      applyStimulus(DROP_A, 32'h0, 1'b0, 1'b0);
      check("ovf_drop", dmem.q_dmem, 32'h1);
      heads = '{8'h41, 8'h42, 8'h43, 8'h44};
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 32'(dmem.tx_valid), 32'h1);
         check("drain_head", 32'(dmem.tx_data), 32'(heads[i]));
         applyStimulus(IDLE_A, 32'h0, 1'b0, 1'b1);
      end
      check("drain_empty", 32'(dmem.tx_valid), 32'h0);

      // Push into a full FIFO while it pops
      for (int i = 0; i < 4; i++) applyStimulus(TX_A, 32'h61 + 32'(i), 1'b1, 1'b0);
      applyStimulus(TX_A, 32'h55, 1'b1, 1'b1);
      applyStimulus(TX_A, 32'h0, 1'b0, 1'b0);
      check("fullpop_status", dmem.q_dmem, 32'h12);
      applyStimulus(DROP_A, 32'h0, 1'b0, 1'b0);
      check("fullpop_drop", dmem.q_dmem, 32'h1);
      heads = '{8'h62, 8'h63, 8'h64, 8'h55};
      for (int i = 0; i < 4; i++) begin
         check("fullpop_head", 32'(dmem.tx_data), 32'(heads[i]));
         applyStimulus(IDLE_A, 32'h0, 1'b0, 1'b1);
      end
      check("fullpop_empty", 32'(dmem.tx_valid), 32'h0);

      // Any write clears DROP
      applyStimulus(DROP_A, 32'hFFFF_FFFF, 1'b1, 1'b0);
      applyStimulus(DROP_A, 32'h0, 1'b0, 1'b0);
      check("drop_clear", dmem.q_dmem, 32'h0);

      // Asynchronous reset mid-cycle with a store pending and FIFO occupied
      applyStimulus(32'd9, 32'h1111, 1'b1, 1'b0);
      applyStimulus(TX_A, 32'h77, 1'b1, 1'b0);
      applyStimulus(LED_A, 32'h3C, 1'b1, 1'b0);
      dmem.address_dmem = 32'd9;
      dmem.data         = 32'h2222;
      dmem.wren         = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("async_leds", 32'(leds), 32'h0);
      check("async_q", dmem.q_dmem, 32'h0);
      check("async_tx_valid", 32'(dmem.tx_valid), 32'h0);
      resetModel();
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(32'd9, 32'h0, 1'b0, 1'b0);
      check("async_store_dropped", dmem.q_dmem, 32'h1111);

      // Randomized traffic over RAM (with aliasing) and the MMIO window
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) a = ($urandom() & 32'h0003_0000) | 32'($urandom_range(0, 15));
         else                           a = CYCLE_A | 32'($urandom_range(0, 7));
         applyStimulus(a, $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
